// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressed data memory: one load/store per transaction, registered
// response after WAIT_STATES wait cycles, little-endian, faulting accesses never write.
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        fault
);

  localparam int          AW        = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH_BYTES);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Access size code: 0 byte, 1 half, 2 word.
  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b001:         return 2'd2;
      3'b101, 3'b110, 3'b111: return 2'd1;
      default:                return 2'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b100) || (op == 3'b111);
  endfunction

  function automatic logic access_fault(input logic [2:0] op, input logic [31:0] a);
    logic [1:0] sz;
    sz = op_size(op);
    return (a >= DEPTH_W) || ((sz == 2'd2) && (a[1:0] != 2'b00)) ||
           ((sz == 2'd1) && a[0]);
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [7:0] b0,
                                              input logic [7:0] b1, input logic [7:0] b2,
                                              input logic [7:0] b3);
    case (op)
      3'b000:  return {b3, b2, b1, b0};
      3'b010:  return {{24{b0[7]}}, b0};
      3'b011:  return {24'd0, b0};
      3'b101:  return {{16{b1[7]}}, b1, b0};
      3'b110:  return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  logic [7:0]    mem_r [DEPTH_BYTES];
  state_t        state_r, state_nxt_s;
  logic [3:0]    cnt_r;
  logic [2:0]    op_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wd_r;
  logic          fault_r;
  logic          resp_valid_r;
  logic [31:0]   read_data_r;
  logic          fault_out_r;

  logic          accept_s;
  logic          req_fault_s;
  logic          enter_resp_s;
  logic [2:0]    acc_op_s;
  logic [AW-1:0] acc_idx_s;
  logic [31:0]   acc_wd_s;
  logic          acc_fault_s;
  logic [1:0]    acc_size_s;
  logic [AW-1:0] idx1_s, idx2_s, idx3_s;
  logic [31:0]   load_val_s;

  assign req_ready    = (state_r == IDLE) && rst_n;
  assign accept_s     = req_valid && req_ready;
  assign req_fault_s  = access_fault(mem_op, addr);
  assign resp_valid   = resp_valid_r;
  assign read_data    = read_data_r;
  assign fault        = fault_out_r;

  // The access that completes on this edge: live inputs when accepting straight into
  // RESP from IDLE, otherwise the values latched at acceptance.
  always_comb begin
    acc_op_s    = op_r;
    acc_idx_s   = addr_r;
    acc_wd_s    = wd_r;
    acc_fault_s = fault_r;
    if (state_r == IDLE) begin
      acc_op_s    = mem_op;
      acc_idx_s   = addr[AW-1:0];
      acc_wd_s    = write_data;
      acc_fault_s = req_fault_s;
    end else begin
      acc_op_s    = op_r;
    end
  end

  assign acc_size_s = op_size(acc_op_s);
  assign idx1_s     = acc_idx_s + AW'(1);
  assign idx2_s     = acc_idx_s + AW'(2);
  assign idx3_s     = acc_idx_s + AW'(3);
  assign load_val_s = load_extend(acc_op_s, mem_r[acc_idx_s], mem_r[idx1_s],
                                  mem_r[idx2_s], mem_r[idx3_s]);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = (req_fault_s || (WAIT_STATES == 0)) ? RESP : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign enter_resp_s = (state_nxt_s == RESP) && (state_r != RESP);

  // State, wait counter, request latch and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      op_r         <= 3'd0;
      addr_r       <= '0;
      wd_r         <= 32'd0;
      fault_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      read_data_r  <= 32'd0;
      fault_out_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && (state_nxt_s == WAIT)) begin
        cnt_r <= WAIT_LOAD;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (accept_s) begin
        op_r    <= mem_op;
        addr_r  <= addr[AW-1:0];
        wd_r    <= write_data;
        fault_r <= req_fault_s;
      end
      resp_valid_r <= enter_resp_s;
      if (enter_resp_s) begin
        read_data_r <= (acc_fault_s || is_store(acc_op_s)) ? 32'd0 : load_val_s;
        fault_out_r <= acc_fault_s;
      end else begin
        read_data_r <= 32'd0;
        fault_out_r <= 1'b0;
      end
    end
  end

  // Byte-lane store on the edge entering RESP; contents are never reset.
  always_ff @(posedge clk) begin
    if (enter_resp_s && is_store(acc_op_s) && !acc_fault_s) begin
      mem_r[acc_idx_s] <= acc_wd_s[7:0];
      if (acc_size_s != 2'd0) begin
        mem_r[idx1_s] <= acc_wd_s[15:8];
      end
      if (acc_size_s == 2'd2) begin
        mem_r[idx2_s] <= acc_wd_s[23:16];
        mem_r[idx3_s] <= acc_wd_s[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: three data_mem_ctrl instances (WAIT_STATES 1, 3, 0) checked
// against a byte-array reference model with directed and randomized transactions.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;
  localparam logic [2:0] OP_LW = 3'd0, OP_SW = 3'd1, OP_LB = 3'd2, OP_LBU = 3'd3,
                         OP_SB = 3'd4, OP_LH = 3'd5, OP_LHU = 3'd6, OP_SH = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [2:0]  mem_op     [3];
  logic [31:0] addr       [3];
  logic [31:0] write_data [3];
  logic        resp_valid [3];
  logic [31:0] read_data  [3];
  logic        fault      [3];

  int errors = 0;
  int checks = 0;
  int ws_of [3] = '{1, 3, 0};
  logic [7:0] model [3][DEPTH];

  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .mem_op(mem_op[0]), .addr(addr[0]), .write_data(write_data[0]),
    .resp_valid(resp_valid[0]), .read_data(read_data[0]), .fault(fault[0]));
  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .mem_op(mem_op[1]), .addr(addr[1]), .write_data(write_data[1]),
    .resp_valid(resp_valid[1]), .read_data(read_data[1]), .fault(fault[1]));
  data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .mem_op(mem_op[2]), .addr(addr[2]), .write_data(write_data[2]),
    .resp_valid(resp_valid[2]), .read_data(read_data[2]), .fault(fault[2]));

  // Reference model: access width, fault rule, little-endian load with extension.
  function automatic int op_bytes(input logic [2:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit op_is_store(input logic [2:0] op);
    return op == OP_SW || op == OP_SB || op == OP_SH;
  endfunction

  function automatic bit exp_fault(input logic [2:0] op, input logic [31:0] a);
    return (a >= 32'(DEPTH)) || ((a % 32'(op_bytes(op))) != 32'd0);
  endfunction

  function automatic logic [31:0] exp_load(input int k, input logic [2:0] op,
                                           input logic [31:0] a);
    longint v = 0;
    for (int i = 0; i < op_bytes(op); i++)
      v = v + longint'(model[k][a + 32'(i)]) * (longint'(1) << (8 * i));
    if (op == OP_LB && v >= 128) v = v - 256;
    if (op == OP_LH && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  function automatic void model_store(input int k, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < op_bytes(op); i++)
      model[k][a + 32'(i)] = 8'((wd >> (8 * i)) & 32'hFF);
  endfunction

  // One transaction: present at a falling edge, accept at the next rising edge, then
  // count falling edges until resp_valid (lat=0 if none within the budget).
  task automatic run_txn(input int k, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, output logic rdy, output logic [31:0] rd,
                         output logic flt, output int lat);
    @(negedge clk);
    req_valid[k] = 1'b1; mem_op[k] = op; addr[k] = a; write_data[k] = wd;
    #1 rdy = req_ready[k];
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0; mem_op[k] = 3'($urandom); addr[k] = $urandom;
    write_data[k] = $urandom;
    lat = 0; rd = 32'd0; flt = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid[k] === 1'b1) begin
        lat = i; rd = read_data[k]; flt = fault[k];
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; mem_op[k] = 3'd0; addr[k] = 32'd0;
      write_data[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (req_ready[k] !== 1'b0) begin errors++; $display("FAIL reset_ready k=%0d got %b want 0", k, req_ready[k]); end
      if (resp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_valid k=%0d got %b want 0", k, resp_valid[k]); end
      if (read_data[k] !== 32'd0) begin errors++; $display("FAIL reset_rdata k=%0d got %h want 0", k, read_data[k]); end
      if (fault[k] !== 1'b0) begin errors++; $display("FAIL reset_fault k=%0d got %b want 0", k, fault[k]); end
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL release_ready k=%0d got %b want 1", k, req_ready[k]); end
    end
  endtask

  logic [2:0]  d_op [11] = '{OP_SW, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SH, OP_LW,
                             OP_LW, OP_SB, OP_LBU};
  logic [31:0] d_a  [11] = '{32'h10, 32'h10, 32'h10, 32'h13, 32'h12, 32'h10, 32'h11,
                             32'h10, 32'(DEPTH), 32'(DEPTH - 1), 32'(DEPTH - 1)};
  logic [31:0] d_wd [11] = '{32'hA1B2C3D4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234,
                             32'h0, 32'h0, 32'h55, 32'h0};
  logic [31:0] d_rd [11] = '{32'h0, 32'hA1B2C3D4, 32'hFFFFFFD4, 32'h000000A1, 32'hFFFFA1B2,
                             32'h0000C3D4, 32'h0, 32'hA1B2C3D4, 32'h0, 32'h0, 32'h55};
  logic        d_f  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_directed();
    logic rdy, flt; logic [31:0] rd; int lat;
    for (int i = 0; i < 11; i++) begin
      run_txn(0, d_op[i], d_a[i], d_wd[i], rdy, rd, flt, lat);
      if (op_is_store(d_op[i]) && !d_f[i]) model_store(0, d_op[i], d_a[i], d_wd[i]);
      checks += 4;
      if (rdy !== 1'b1) begin errors++; $display("FAIL dir_ready #%0d got %b want 1", i, rdy); end
      if (lat != (d_f[i] ? 1 : 2)) begin errors++; $display("FAIL dir_latency #%0d got %0d want %0d", i, lat, d_f[i] ? 1 : 2); end
      if (rd !== d_rd[i]) begin errors++; $display("FAIL dir_rdata #%0d got %h want %h", i, rd, d_rd[i]); end
      if (flt !== d_f[i]) begin errors++; $display("FAIL dir_fault #%0d got %b want %b", i, flt, d_f[i]); end
    end
  endtask

  task automatic test_random();
    logic rdy, flt, ef; logic [31:0] rd, a, wd, er; logic [2:0] op; int lat, el;
    for (int i = 0; i < 76; i++) begin
      if (i < 16) begin
        op = OP_SW; a = 32'(4 * i);
      end else begin
        op = 3'($urandom_range(0, 7));
        a  = 32'($urandom_range(0, DEPTH + 7));
        if ($urandom_range(0, 3) != 0) a = a & ~32'(op_bytes(op) - 1);
      end
      wd = $urandom;
      ef = exp_fault(op, a);
      er = (ef || op_is_store(op)) ? 32'd0 : exp_load(0, op, a);
      el = ef ? 1 : ws_of[0] + 1;
      run_txn(0, op, a, wd, rdy, rd, flt, lat);
      if (op_is_store(op) && !ef) model_store(0, op, a, wd);
      checks += 3;
      if (lat != el) begin errors++; $display("FAIL rnd_latency #%0d op=%0d a=%h got %0d want %0d", i, op, a, lat, el); end
      if (rd !== er) begin errors++; $display("FAIL rnd_rdata #%0d op=%0d a=%h got %h want %h", i, op, a, rd, er); end
      if (flt !== ef) begin errors++; $display("FAIL rnd_fault #%0d op=%0d a=%h got %b want %b", i, op, a, flt, ef); end
    end
  endtask

  task automatic test_reset_abort();
    logic rdy, flt, seen; logic [31:0] rd; int lat;
    run_txn(1, OP_SW, 32'h20, 32'h11223344, rdy, rd, flt, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL ws3_store_latency got %0d want 4", lat); end
    @(negedge clk);
    req_valid[1] = 1'b1; mem_op[1] = OP_SW; addr[1] = 32'h20; write_data[1] = 32'hDEADBEEF;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(posedge clk); #1 rst_n[1] = 1'b0;
    #1;
    checks += 2;
    if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL abort_ready_in_reset got %b want 0", req_ready[1]); end
    if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL abort_valid_in_reset got %b want 0", resp_valid[1]); end
    @(negedge clk); @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL abort_ready_after got %b want 1", req_ready[1]); end
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (resp_valid[1] === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_resp got %b want 0", seen); end
    run_txn(1, OP_LW, 32'h20, 32'h0, rdy, rd, flt, lat);
    checks += 2;
    if (rd !== 32'h11223344) begin errors++; $display("FAIL abort_mem_kept got %h want 11223344", rd); end
    if (lat != 4) begin errors++; $display("FAIL abort_load_latency got %0d want 4", lat); end
    // Reset landing in RESP: store already done, outputs drop at once.
    run_txn(1, OP_SW, 32'h24, 32'hCAFEF00D, rdy, rd, flt, lat);
    rst_n[1] = 1'b0;
    #1;
    checks++;
    if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL resp_reset_valid got %b want 0", resp_valid[1]); end
    @(negedge clk) rst_n[1] = 1'b1;
    run_txn(1, OP_LW, 32'h24, 32'h0, rdy, rd, flt, lat);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL resp_reset_mem got %h want cafef00d", rd); end
    rst_n[1] = 1'b0;
    #1;
    checks += 2;
    if (read_data[1] !== 32'd0) begin errors++; $display("FAIL resp_reset_rdata got %h want 0", read_data[1]); end
    if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL resp_reset_valid2 got %b want 0", resp_valid[1]); end
    @(negedge clk) rst_n[1] = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] cur_op; logic [31:0] cur_a, cur_wd, er;
    cur_op = OP_SW; cur_a = 32'd0; cur_wd = 32'd0;
    @(negedge clk);
    for (int t = 0; t < 32; t++) begin
      if (t % 2 == 0) begin
        checks += 2;
        if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL b2b_ready t=%0d got %b want 1", t, req_ready[2]); end
        if (resp_valid[2] !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid t=%0d got %b want 0", t, resp_valid[2]); end
        cur_op = (t % 4 == 0) ? OP_SW : OP_LW;
        if (cur_op == OP_SW) begin
          cur_a = 32'(4 * $urandom_range(0, DEPTH / 4 - 1)); cur_wd = $urandom;
          model_store(2, OP_SW, cur_a, cur_wd);
        end
        req_valid[2] = 1'b1; mem_op[2] = cur_op; addr[2] = cur_a; write_data[2] = cur_wd;
      end else begin
        er = (cur_op == OP_LW) ? exp_load(2, OP_LW, cur_a) : 32'd0;
        checks += 4;
        if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL b2b_busy t=%0d got %b want 0", t, req_ready[2]); end
        if (resp_valid[2] !== 1'b1) begin errors++; $display("FAIL b2b_valid t=%0d got %b want 1", t, resp_valid[2]); end
        if (read_data[2] !== er) begin errors++; $display("FAIL b2b_rdata t=%0d got %h want %h", t, read_data[2], er); end
        if (fault[2] !== 1'b0) begin errors++; $display("FAIL b2b_fault t=%0d got %b want 0", t, fault[2]); end
        mem_op[2] = 3'($urandom); addr[2] = $urandom; write_data[2] = $urandom;
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
